id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
// - ID/EX pipeline register of the 5-stage core. Sits directly downstream of control_unit and the register file.
// - Latches the decoded control bits, operands, immediate, PC and register addresses into the EX stage.
// - Contains load-use hazard detection: stalls PC and IF/ID, then injects one bubble into EX.
// - Applies the branch/jump flush and keeps a saturating counter of stall cycles.
// PARAMETERS
// XLEN        64  datapath width: operands, immediate, PC
// RADDR_W     5   register address width
// CNT_W       16  width of the stall-cycle counter
// PORTS
// clk_i         in   1        core clock; all state updates on rising edge
// reset_i       in   1        asynchronous, active-high reset
// mem_to_reg_i  in   1        ID control from control_unit; may be X when unused
// mem_write_i   in   1        ID control from control_unit
// reg_write_i   in   1        ID control from control_unit
// load_i        in   1        ID control from control_unit; may be X when unused
// store_i       in   1        ID control from control_unit; may be X when unused
// immd_i        in   1        ID control: 1 = B operand is the immediate (rs2 unused); may be X
// jal_i         in   1        ID control from control_unit
// branch_i      in   1        ID control from control_unit
// rs1_data_i    in   XLEN     ID rs1 operand
// rs2_data_i    in   XLEN     ID rs2 operand
// imm_i         in   XLEN     ID sign-extended immediate
// pc_i          in   XLEN     ID PC
// rs1_addr_i    in   RADDR_W  ID source register 1
// rs2_addr_i    in   RADDR_W  ID source register 2
// rd_addr_i     in   RADDR_W  ID destination register
// flush_i       in   1        taken branch/jump: kill the instruction currently in ID
// ex_*_o        out  (same)   registered copy of every input above; e.g. ex_load_o, ex_rd_addr_o
// ex_valid_o    out  1        1 = EX holds a real instruction; 0 = bubble
// stall_o       out  1        combinational; freeze PC and IF/ID this cycle
// stall_cnt_o   out  CNT_W    count of stall cycles, saturating
// BEHAVIOUR
// - Reset (asynchronous): all ex_* outputs, ex_valid_o and stall_cnt_o go to 0 immediately.
//   stall_o is 0 while reset_i is high.
// - Reset mid-stall: the stall is abandoned. The instruction in ID is not replayed by this block.
// - Hazard (combinational): haz = ex_valid_o & ex_load_o & ex_reg_write_o & (ex_rd_addr_o != 0) & rs_match.
//   - rs_match = (ex_rd_addr_o == rs1_addr_i) | (~immd_i & ex_rd_addr_o == rs2_addr_i).
//   - An X on immd_i or load_i is treated as 0: immd_i === 1 means immediate; ex_load_o is registered clean.
//   - If jal_i = 1 there are no sources, so haz = 0.
// - stall_o = haz & ~flush_i.
// - Per-edge action, in priority order:
//   1. flush_i = 1 -> bubble.
//   2. haz = 1 -> bubble. The ID inputs stay held by the upstream stall and are captured next cycle.
//   3. Otherwise -> capture.
// - Bubble: all control outputs (mem_to_reg, mem_write, reg_write, load, store, immd, jal, branch) = 0 and ex_valid_o = 0.
//   Data/address outputs still capture the inputs; their value is don't-care.
// - Capture: every control input is registered with X mapped to 0. Data fields are registered. ex_valid_o = 1.
// - Latency: one cycle from ID to EX.
// - A load-use stall lasts exactly one cycle: the bubble clears ex_load_o, so haz drops.
// - Back-to-back loads feeding each other also stall one cycle per dependent pair.
// - flush_i and haz in the same cycle: flush wins, stall_o = 0, and stall_cnt_o is not incremented.
// - stall_cnt_o increments by 1 on every edge where stall_o = 1. It saturates at 2^CNT_W-1 and never wraps.
// - Dependence on x0 (ex_rd_addr_o = 0) never stalls.
// TESTING
// - Reset pulse asserted asynchronously between clock edges -> all ex_* = 0, ex_valid_o = 0, stall_cnt_o = 0 before the next edge.
// - R-type add rd=5, then in ID an R-type with rs1=3, rs2=4 -> no stall; EX gets rs1_data=64'h11, imm passes through; ex_valid_o = 1 one cycle later.
// - Load rd=7 in EX, R-type rs2=7 in ID -> stall_o = 1 for exactly 1 cycle; EX bubble (ex_valid_o = 0, ex_reg_write_o = 0); next edge captures the R-type; stall_cnt_o = 1.
// - Load rd=7 in EX, I-type addi with rs2 field = 7 (immd_i = 1) in ID -> no stall. Same setup with rd = 0 -> no stall.
// - Load-use hazard together with flush_i = 1 -> stall_o = 0; bubble in EX; stall_cnt_o unchanged.
// - CNT_W = 2; drive 5 load-use hazards -> stall_cnt_o = 3 (saturated, no wrap).

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch/jump flush
// and a saturating stall-cycle counter.
module id_ex_stage_reg #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               mem_to_reg_i,
  input  logic               mem_write_i,
  input  logic               reg_write_i,
  input  logic               load_i,
  input  logic               store_i,
  input  logic               immd_i,
  input  logic               jal_i,
  input  logic               branch_i,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  input  logic [XLEN-1:0]    imm_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [RADDR_W-1:0] rs1_addr_i,
  input  logic [RADDR_W-1:0] rs2_addr_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               flush_i,
  output logic               ex_mem_to_reg_o,
  output logic               ex_mem_write_o,
  output logic               ex_reg_write_o,
  output logic               ex_load_o,
  output logic               ex_store_o,
  output logic               ex_immd_o,
  output logic               ex_jal_o,
  output logic               ex_branch_o,
  output logic [XLEN-1:0]    ex_rs1_data_o,
  output logic [XLEN-1:0]    ex_rs2_data_o,
  output logic [XLEN-1:0]    ex_imm_o,
  output logic [XLEN-1:0]    ex_pc_o,
  output logic [RADDR_W-1:0] ex_rs1_addr_o,
  output logic [RADDR_W-1:0] ex_rs2_addr_o,
  output logic [RADDR_W-1:0] ex_rd_addr_o,
  output logic               ex_valid_o,
  output logic               stall_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  logic w_rs_match;
  logic w_haz;
  logic w_bubble;

  // Load-use detection against the instruction now in EX; X on immd/jal reads as 0
  always_comb begin
    w_rs_match = (ex_rd_addr_o == rs1_addr_i) |
                 ((immd_i !== 1'b1) & (ex_rd_addr_o == rs2_addr_i));
    w_haz      = ex_valid_o & ex_load_o & ex_reg_write_o &
                 (ex_rd_addr_o != '0) & w_rs_match & (jal_i !== 1'b1);
    stall_o    = w_haz & ~flush_i & ~reset_i;
    w_bubble   = flush_i | w_haz;
  end

  // ID -> EX register: data always captured, controls zeroed on a bubble
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ex_mem_to_reg_o <= 1'b0;
      ex_mem_write_o  <= 1'b0;
      ex_reg_write_o  <= 1'b0;
      ex_load_o       <= 1'b0;
      ex_store_o      <= 1'b0;
      ex_immd_o       <= 1'b0;
      ex_jal_o        <= 1'b0;
      ex_branch_o     <= 1'b0;
      ex_valid_o      <= 1'b0;
      ex_rs1_data_o   <= '0;
      ex_rs2_data_o   <= '0;
      ex_imm_o        <= '0;
      ex_pc_o         <= '0;
      ex_rs1_addr_o   <= '0;
      ex_rs2_addr_o   <= '0;
      ex_rd_addr_o    <= '0;
    end else begin
      ex_rs1_data_o <= rs1_data_i;
      ex_rs2_data_o <= rs2_data_i;
      ex_imm_o      <= imm_i;
      ex_pc_o       <= pc_i;
      ex_rs1_addr_o <= rs1_addr_i;
      ex_rs2_addr_o <= rs2_addr_i;
      ex_rd_addr_o  <= rd_addr_i;
      if (w_bubble) begin
        ex_mem_to_reg_o <= 1'b0;
        ex_mem_write_o  <= 1'b0;
        ex_reg_write_o  <= 1'b0;
        ex_load_o       <= 1'b0;
        ex_store_o      <= 1'b0;
        ex_immd_o       <= 1'b0;
        ex_jal_o        <= 1'b0;
        ex_branch_o     <= 1'b0;
        ex_valid_o      <= 1'b0;
      end else begin
        ex_mem_to_reg_o <= (mem_to_reg_i === 1'b1);
        ex_mem_write_o  <= (mem_write_i === 1'b1);
        ex_reg_write_o  <= (reg_write_i === 1'b1);
        ex_load_o       <= (load_i === 1'b1);
        ex_store_o      <= (store_i === 1'b1);
        ex_immd_o       <= (immd_i === 1'b1);
        ex_jal_o        <= (jal_i === 1'b1);
        ex_branch_o     <= (branch_i === 1'b1);
        ex_valid_o      <= 1'b1;
      end
    end
  end

  // Saturating count of stall cycles
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, capture, load-use stall, immediate
// and x0 exemptions, X-clean controls, flush priority and counter saturation.
module tb_id_ex_stage_reg;

  localparam logic [7:0] C_R    = 8'b0010_0000; // {m2r,mw,rw,ld,st,immd,jal,br}
  localparam logic [7:0] C_LD   = 8'b1011_0100;
  localparam logic [7:0] C_ADDI = 8'b0010_0100;
  localparam logic [7:0] C_JAL  = 8'b0010_0010;
  localparam logic [7:0] C_NOP  = 8'b0000_0000;

  logic        clk_i = 1'b0, reset_i = 1'b1;
  logic        mem_to_reg_i, mem_write_i, reg_write_i, load_i, store_i, immd_i, jal_i, branch_i;
  logic [63:0] rs1_data_i, rs2_data_i, imm_i, pc_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        flush_i;

  logic        ex_mem_to_reg_o, ex_mem_write_o, ex_reg_write_o, ex_load_o, ex_store_o;
  logic        ex_immd_o, ex_jal_o, ex_branch_o, ex_valid_o, stall_o;
  logic [63:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o;
  logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
  logic [15:0] stall_cnt_o;

  logic        s_m2r, s_mw, s_rw, s_ld, s_st, s_immd, s_jal, s_br, s_valid, s_stall;
  logic [63:0] s_rs1d, s_rs2d, s_imm, s_pc;
  logic [4:0]  s_rs1a, s_rs2a, s_rda;
  logic [1:0]  s_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int unsigned exp_cnt = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage_reg #(.XLEN(64), .RADDR_W(5), .CNT_W(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mem_to_reg_i(mem_to_reg_i), .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
    .load_i(load_i), .store_i(store_i), .immd_i(immd_i), .jal_i(jal_i), .branch_i(branch_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .pc_i(pc_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
    .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_load_o(ex_load_o), .ex_store_o(ex_store_o),
    .ex_immd_o(ex_immd_o), .ex_jal_o(ex_jal_o), .ex_branch_o(ex_branch_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
    .ex_pc_o(ex_pc_o), .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_valid_o(ex_valid_o), .stall_o(stall_o),
    .stall_cnt_o(stall_cnt_o)
  );

  id_ex_stage_reg #(.XLEN(64), .RADDR_W(5), .CNT_W(2)) dut_small (
    .clk_i(clk_i), .reset_i(reset_i),
    .mem_to_reg_i(mem_to_reg_i), .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
    .load_i(load_i), .store_i(store_i), .immd_i(immd_i), .jal_i(jal_i), .branch_i(branch_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .pc_i(pc_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
    .ex_mem_to_reg_o(s_m2r), .ex_mem_write_o(s_mw), .ex_reg_write_o(s_rw),
    .ex_load_o(s_ld), .ex_store_o(s_st), .ex_immd_o(s_immd), .ex_jal_o(s_jal),
    .ex_branch_o(s_br), .ex_rs1_data_o(s_rs1d), .ex_rs2_data_o(s_rs2d), .ex_imm_o(s_imm),
    .ex_pc_o(s_pc), .ex_rs1_addr_o(s_rs1a), .ex_rs2_addr_o(s_rs2a), .ex_rd_addr_o(s_rda),
    .ex_valid_o(s_valid), .stall_o(s_stall), .stall_cnt_o(s_cnt)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic [7:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd);
    {mem_to_reg_i, mem_write_i, reg_write_i, load_i, store_i, immd_i, jal_i, branch_i} = ctrl;
    rs1_addr_i = rs1;
    rs2_addr_i = rs2;
    rd_addr_i  = rd;
    rs1_data_i = 64'h1000 + 64'(rs1);
    rs2_data_i = 64'h2000 + 64'(rs2);
    imm_i      = 64'h30;
    pc_i       = pc_i + 64'd4;
  endtask

  task automatic test_reset();
    set_id(C_R, 5'd1, 5'd2, 5'd3);
    reset_i = 1'b0;
    step();
    total_cnt++; if (ex_valid_o !== 1'b1) $display("FAIL rst_pre_valid got=%0h exp=1", ex_valid_o); else pass_cnt++;
    #3 reset_i = 1'b1;
    #1;
    total_cnt++; if (ex_valid_o !== 1'b0) $display("FAIL rst_valid got=%0h exp=0", ex_valid_o); else pass_cnt++;
    total_cnt++; if (ex_reg_write_o !== 1'b0) $display("FAIL rst_reg_write got=%0h exp=0", ex_reg_write_o); else pass_cnt++;
    total_cnt++; if (ex_rs1_data_o !== 64'h0) $display("FAIL rst_rs1_data got=%0h exp=0", ex_rs1_data_o); else pass_cnt++;
    total_cnt++; if (ex_pc_o !== 64'h0) $display("FAIL rst_pc got=%0h exp=0", ex_pc_o); else pass_cnt++;
    total_cnt++; if (ex_rd_addr_o !== 5'd0) $display("FAIL rst_rd got=%0h exp=0", ex_rd_addr_o); else pass_cnt++;
    total_cnt++; if (stall_cnt_o !== 16'd0) $display("FAIL rst_cnt got=%0h exp=0", stall_cnt_o); else pass_cnt++;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL rst_stall got=%0h exp=0", stall_o); else pass_cnt++;
    #1 reset_i = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_no_stall();
    set_id(C_R, 5'd1, 5'd2, 5'd5);
    step();
    set_id(C_R, 5'd3, 5'd4, 5'd6);
    rs1_data_i = 64'h11;
    imm_i      = 64'hABC;
    #1;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL nostall_stall got=%0h exp=0", stall_o); else pass_cnt++;
    step();
    total_cnt++; if (ex_valid_o !== 1'b1) $display("FAIL nostall_valid got=%0h exp=1", ex_valid_o); else pass_cnt++;
    total_cnt++; if (ex_rs1_data_o !== 64'h11) $display("FAIL nostall_rs1 got=%0h exp=11", ex_rs1_data_o); else pass_cnt++;
    total_cnt++; if (ex_imm_o !== 64'hABC) $display("FAIL nostall_imm got=%0h exp=abc", ex_imm_o); else pass_cnt++;
    total_cnt++; if (ex_rd_addr_o !== 5'd6) $display("FAIL nostall_rd got=%0h exp=6", ex_rd_addr_o); else pass_cnt++;
  endtask

  task automatic test_load_use();
    set_id(C_LD, 5'd1, 5'd0, 5'd7);
    step();
    set_id(C_R, 5'd1, 5'd7, 5'd8);
    #1;
    total_cnt++; if (stall_o !== 1'b1) $display("FAIL lu_stall got=%0h exp=1", stall_o); else pass_cnt++;
    step();
    exp_cnt++;
    total_cnt++; if (ex_valid_o !== 1'b0) $display("FAIL lu_bubble_valid got=%0h exp=0", ex_valid_o); else pass_cnt++;
    total_cnt++; if (ex_reg_write_o !== 1'b0) $display("FAIL lu_bubble_rw got=%0h exp=0", ex_reg_write_o); else pass_cnt++;
    total_cnt++; if (ex_load_o !== 1'b0) $display("FAIL lu_bubble_ld got=%0h exp=0", ex_load_o); else pass_cnt++;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL lu_stall_drop got=%0h exp=0", stall_o); else pass_cnt++;
    total_cnt++; if (stall_cnt_o !== 16'(exp_cnt)) $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt_o, exp_cnt); else pass_cnt++;
    step();
    total_cnt++; if (ex_valid_o !== 1'b1) $display("FAIL lu_cap_valid got=%0h exp=1", ex_valid_o); else pass_cnt++;
    total_cnt++; if (ex_rd_addr_o !== 5'd8) $display("FAIL lu_cap_rd got=%0h exp=8", ex_rd_addr_o); else pass_cnt++;
    total_cnt++; if (ex_reg_write_o !== 1'b1) $display("FAIL lu_cap_rw got=%0h exp=1", ex_reg_write_o); else pass_cnt++;
    total_cnt++; if (ex_rs2_data_o !== 64'h2007) $display("FAIL lu_cap_rs2 got=%0h exp=2007", ex_rs2_data_o); else pass_cnt++;
  endtask

  task automatic test_exemptions();
    // immediate form ignores rs2 field
    set_id(C_LD, 5'd1, 5'd0, 5'd7);
    step();
    set_id(C_ADDI, 5'd2, 5'd7, 5'd9);
    #1;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL immd_stall got=%0h exp=0", stall_o); else pass_cnt++;
    step();
    total_cnt++; if (ex_immd_o !== 1'b1) $display("FAIL immd_cap got=%0h exp=1", ex_immd_o); else pass_cnt++;
    // load to x0 never stalls
    set_id(C_LD, 5'd1, 5'd0, 5'd0);
    step();
    set_id(C_R, 5'd0, 5'd0, 5'd9);
    #1;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL x0_stall got=%0h exp=0", stall_o); else pass_cnt++;
    // jal has no sources
    set_id(C_LD, 5'd1, 5'd0, 5'd7);
    step();
    set_id(C_JAL, 5'd7, 5'd7, 5'd1);
    #1;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL jal_stall got=%0h exp=0", stall_o); else pass_cnt++;
    // X on immd counts as 0: rs2 match stalls
    set_id(C_R, 5'd2, 5'd7, 5'd9);
    immd_i = 1'bx;
    #1;
    total_cnt++; if (stall_o !== 1'b1) $display("FAIL ximmd_stall got=%0h exp=1", stall_o); else pass_cnt++;
    step();
    exp_cnt++;
    // X controls registered as 0
    set_id(C_R, 5'd2, 5'd3, 5'd9);
    {mem_to_reg_i, load_i, store_i, immd_i} = 4'bxxxx;
    step();
    total_cnt++; if (ex_valid_o !== 1'b1) $display("FAIL xctl_valid got=%0h exp=1", ex_valid_o); else pass_cnt++;
    total_cnt++; if ({ex_mem_to_reg_o, ex_load_o, ex_store_o, ex_immd_o} !== 4'b0000)
      $display("FAIL xctl_clean got=%0b exp=0000", {ex_mem_to_reg_o, ex_load_o, ex_store_o, ex_immd_o}); else pass_cnt++;
    total_cnt++; if (ex_reg_write_o !== 1'b1) $display("FAIL xctl_rw got=%0h exp=1", ex_reg_write_o); else pass_cnt++;
  endtask

  task automatic test_flush();
    set_id(C_LD, 5'd1, 5'd0, 5'd7);
    step();
    set_id(C_R, 5'd7, 5'd2, 5'd8);
    flush_i = 1'b1;
    #1;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL flush_stall got=%0h exp=0", stall_o); else pass_cnt++;
    step();
    flush_i = 1'b0;
    total_cnt++; if (ex_valid_o !== 1'b0) $display("FAIL flush_valid got=%0h exp=0", ex_valid_o); else pass_cnt++;
    total_cnt++; if (ex_reg_write_o !== 1'b0) $display("FAIL flush_rw got=%0h exp=0", ex_reg_write_o); else pass_cnt++;
    total_cnt++; if (stall_cnt_o !== 16'(exp_cnt)) $display("FAIL flush_cnt got=%0d exp=%0d", stall_cnt_o, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    set_id(C_LD, 5'd1, 5'd0, 5'd9);
    step();
    set_id(C_LD, 5'd9, 5'd0, 5'd10);
    #1;
    total_cnt++; if (stall_o !== 1'b1) $display("FAIL b2b_stall1 got=%0h exp=1", stall_o); else pass_cnt++;
    step();
    exp_cnt++;
    step();
    total_cnt++; if ({ex_valid_o, ex_load_o, ex_rd_addr_o} !== {1'b1, 1'b1, 5'd10})
      $display("FAIL b2b_ld2 got=%0h exp=%0h", {ex_valid_o, ex_load_o, ex_rd_addr_o}, {1'b1, 1'b1, 5'd10}); else pass_cnt++;
    set_id(C_R, 5'd10, 5'd3, 5'd11);
    #1;
    total_cnt++; if (stall_o !== 1'b1) $display("FAIL b2b_stall2 got=%0h exp=1", stall_o); else pass_cnt++;
    step();
    exp_cnt++;
    step();
    total_cnt++; if (stall_cnt_o !== 16'(exp_cnt)) $display("FAIL b2b_cnt got=%0d exp=%0d", stall_cnt_o, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      set_id(C_LD, 5'd0, 5'd0, 5'd7);
      step();
      set_id(C_R, 5'd2, 5'd7, 5'd8);
      #1;
      total_cnt++; if (stall_o !== 1'b1) $display("FAIL sat_stall%0d got=%0h exp=1", i, stall_o); else pass_cnt++;
      step();
      exp_cnt++;
      step();
    end
    total_cnt++; if (stall_cnt_o !== 16'(exp_cnt)) $display("FAIL sat_cnt16 got=%0d exp=%0d", stall_cnt_o, exp_cnt); else pass_cnt++;
    total_cnt++; if (s_cnt !== 2'd3) $display("FAIL sat_cnt2 got=%0d exp=3", s_cnt); else pass_cnt++;
  endtask

  initial begin
    pc_i    = 64'h0;
    flush_i = 1'b0;
    set_id(C_NOP, 5'd0, 5'd0, 5'd0);
    step();
    step();
    test_reset();
    test_no_stall();
    test_load_use();
    test_exemptions();
    test_flush();
    test_back_to_back();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
